microsequencer_param: RTL
=========================

Name: microsequencer_param

Overview:
- Parametrised microprogrammed sequencer for the ARM datapath control path.
- Contains:
  - the micro-PC (upc),
  - a writable microstore,
  - a selectable/invertible condition mux,
  - next-address logic,
  - a micro-subroutine return stack.
- Takes the decoded entry address from the external instruction encoder and the MOC/Cond-style status lines.
- Emits a registered control word plus the current state to the datapath each cycle.

Parameters:
- AW, 7, micro-address width; microstore depth = 2**AW.
- MOORE_W, 26, Moore control-line field width.
- CSEL_W, 2, condition-select width; NCOND = 2**CSEL_W condition inputs.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, micro-address entered on reset.
- WDOG_LIMIT, 15, watchdog cycle limit (used only with CU_WATCHDOG_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  1 = freeze upc, cw, stack and flags.
- decode_addr  in  AW  entry address from instruction encoder.
- cond_in  in  NCOND  status inputs; bit 0 = MOC, bit 1 = Cond, others are spare.
- ms_we  in  1  microstore write enable.
- ms_waddr  in  AW  microstore write address.
- ms_wdata  in  CW_W  microstore write data.
- cw  out  CW_W  registered control word.
- state  out  AW  current upc.
- stk_ovf  out  1  sticky flag: push attempted while stack full.
- stk_unf  out  1  sticky flag: pop attempted while stack empty.
- wdog_to  out  1  sticky watchdog timeout; tied 0 without macro.

Behaviour:
- Control word layout: CW_W = 3+1+CSEL_W+MOORE_W+AW = 39 by default, MSB first {ns[2:0], inv, csel, moore, target}.
- Status: sts = cond_in[csel] ^ inv, taken from the current cw.
- Next address by ns:
  - 0 DECODE: decode_addr.
  - 1 INC: upc+1.
  - 2 JUMP: target.
  - 3 CJUMP: sts ? target : upc+1.
  - 4 CWAIT: sts ? upc+1 : upc (wait-for-MOC).
  - 5 CALL: push upc+1, go to target.
  - 6 RET: pop into next.
  - 7 CDECODE: sts ? decode_addr : target.
- upc+1 wraps modulo 2**AW.
- Each rising edge with reset=1 and stall=0:
  - upc <= next;
  - cw <= mem[next];
  - state = upc.
  - Latency from status change to new cw: 1 cycle.
- stall=1: all state holds; ms_we writes still occur.
- Reset (reset=0 at edge):
  - upc <= RESET_ADDR; cw <= mem[RESET_ADDR];
  - stack pointer <= 0;
  - stk_ovf, stk_unf, wdog_to <= 0;
  - microstore contents are preserved.
  - Reset overrides stall.
  - Reset mid-CWAIT or mid-subroutine abandons it.
- Stack is LIFO with sp from 0 to STACK_DEPTH.
  - CALL with sp=STACK_DEPTH: jump still taken, push dropped, stk_ovf <= 1.
  - RET with sp=0: next = RESET_ADDR, stk_unf <= 1.
- Microstore write: on edge with ms_we=1, mem[ms_waddr] <= ms_wdata.
  - If ms_waddr == next on the same edge, cw gets old data (read-before-write).
  - Write occurs regardless of reset and stall.
- No initial-block contents are required; the bench loads via the write port or $readmemb.

Optional Feature:
- Macro: CU_WATCHDOG_EN.
- Enabled:
  - A counter increments each non-stalled cycle the sequencer stays in CWAIT at the same upc, and clears on leaving.
  - When the count reaches WDOG_LIMIT with sts still 0: next = target, wdog_to <= 1 (sticky until reset), counter clears.
- Disabled: no counter; wdog_to is constant 0; CWAIT may hold indefinitely.

Test Plan:
- Reset/fetch: load mem[0]={INC}, mem[1]={DECODE}; hold reset=0 for 2 cycles, then release with decode_addr=5.
  - Required: state sequence 0,1,5.
  - Required: cw equals mem[state] each cycle.
- Wait-for-MOC: mem[11]={CWAIT, csel=0, inv=0}, MOC=0 for 3 cycles then 1.
  - Required: state stays 11 for 3 cycles, then 12 one cycle after MOC rises.
  - Same sequence with stall=1 for 2 cycles mid-wait: state and cw frozen.
- Conditional branch: mem[64]={CDECODE, csel=1, inv=0, target=1}.
  - Cond=1 -> next=decode_addr (8).
  - Cond=0 -> next=1.
  - With inv=1, the two outcomes swap.
- Subroutine: CALL target=100 from upc 20; RET at 100.
  - Required: state 20,100,21.
  - Five nested CALLs with STACK_DEPTH=4 -> stk_ovf=1, fifth return path lost.
  - RET with empty stack -> state=RESET_ADDR, stk_unf=1.
- Wrap and write hazard:
  - INC at upc=127 -> state 0.
  - ms_we to the address being fetched -> cw shows old word, new word on next visit.
  - Reset asserted mid-subroutine -> sp=0, flags 0.
- CU_WATCHDOG_EN (WDOG_LIMIT=15): CWAIT at 11 with MOC stuck 0.
  - Required: after 15 cycles at 11, state=target, wdog_to=1.
  - Without the macro: state stays 11, wdog_to=0.

Source files
------------

// File: rtl/microsequencer_param.sv
// Parametrised microprogrammed sequencer: micro-PC, writable microstore, condition mux, return stack.
// Optional CWAIT watchdog enabled by defining CU_WATCHDOG_EN.
module microsequencer_param #(
  parameter int AW          = 7,
  parameter int MOORE_W     = 26,
  parameter int CSEL_W      = 2,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int WDOG_LIMIT  = 15,
  localparam int NCOND      = 1 << CSEL_W,
  localparam int CW_W       = 3 + 1 + CSEL_W + MOORE_W + AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [AW-1:0]     decode_addr,
  input  logic [NCOND-1:0]  cond_in,
  input  logic              ms_we,
  input  logic [AW-1:0]     ms_waddr,
  input  logic [CW_W-1:0]   ms_wdata,
  output logic [CW_W-1:0]   cw,
  output logic [AW-1:0]     state,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              wdog_to
);

  localparam logic [2:0] NS_DECODE  = 3'd0;
  localparam logic [2:0] NS_INC     = 3'd1;
  localparam logic [2:0] NS_JUMP    = 3'd2;
  localparam logic [2:0] NS_CJUMP   = 3'd3;
  localparam logic [2:0] NS_CWAIT   = 3'd4;
  localparam logic [2:0] NS_CALL    = 3'd5;
  localparam logic [2:0] NS_RET     = 3'd6;

  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SPW;
  localparam logic [AW-1:0] RST_A = AW'(RESET_ADDR);

  logic [CW_W-1:0]   mem [1 << AW];
  logic [AW-1:0]     stk [SLOTS];
  logic [AW-1:0]     upc, nxt, inc, target;
  logic [SPW-1:0]    sp;
  logic [2:0]        ns;
  logic [CSEL_W-1:0] csel;
  logic              inv, sts;
  logic              push, pop, ovf_set, unf_set;

  assign ns     = cw[CW_W-1 -: 3];
  assign inv    = cw[CW_W-4];
  assign csel   = cw[AW+MOORE_W +: CSEL_W];
  assign target = cw[AW-1:0];
  assign inc    = upc + AW'(1);
  assign sts    = cond_in[csel] ^ inv;
  assign state  = upc;

`ifdef CU_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);
  logic [WCW-1:0] wcnt;
  logic           wd_fire;
`endif

  // next-address selection from the current control word
  always_comb begin
    nxt     = inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
`ifdef CU_WATCHDOG_EN
    wd_fire = 1'b0;
`endif
    case (ns)
      NS_DECODE: nxt = decode_addr;
      NS_INC:    nxt = inc;
      NS_JUMP:   nxt = target;
      NS_CJUMP:  nxt = sts ? target : inc;
      NS_CWAIT: begin
        if (sts) nxt = inc;
`ifdef CU_WATCHDOG_EN
        else if (wcnt == WCW'(WDOG_LIMIT - 1)) begin
          nxt     = target;
          wd_fire = 1'b1;
        end
`endif
        else nxt = upc;
      end
      NS_CALL: begin
        nxt = target;
        if (sp == SPW'(STACK_DEPTH)) ovf_set = 1'b1;
        else                         push    = 1'b1;
      end
      NS_RET: begin
        if (sp == '0) begin
          nxt     = RST_A;
          unf_set = 1'b1;
        end else begin
          nxt = stk[sp - SPW'(1)];
          pop = 1'b1;
        end
      end
      default: nxt = sts ? decode_addr : target;
    endcase
  end

  // stage p0: micro-PC, control word, stack pointer and sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      upc     <= RST_A;
      cw      <= mem[RST_A];
      sp      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (!stall) begin
      upc <= nxt;
      cw  <= mem[nxt];
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (ovf_set) stk_ovf <= 1'b1;
      if (unf_set) stk_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !stall && push) stk[sp] <= inc;
  end

  // fetch above reads the old word, so a same-edge write to the fetched address shows up next visit
  always_ff @(posedge clk) begin
    if (ms_we) mem[ms_waddr] <= ms_wdata;
  end

`ifdef CU_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt    <= '0;
      wdog_to <= 1'b0;
    end else if (!stall) begin
      wcnt <= (ns == NS_CWAIT && !sts && !wd_fire) ? wcnt + WCW'(1) : '0;
      if (wd_fire) wdog_to <= 1'b1;
    end
  end
`else
  assign wdog_to = 1'b0;
`endif

endmodule
